// File: rtl/ppi_pkg.sv
// Shared field positions and state types for the PPI group B controller.
package ppi_pkg;

    // Control word fields
    localparam int CW_MODESET = 7;
    localparam int CW_MODE_B  = 2;
    localparam int CW_DIR_B   = 1;
    localparam int CW_DIR_CL  = 0;
    localparam int BSR_SEL_HI = 3;
    localparam int BSR_SEL_LO = 1;
    localparam int BSR_VAL    = 0;

    // Port C-lower pin roles in mode 1
    localparam int PC_INTR    = 0;
    localparam int PC_BF      = 1;
    localparam int PC_STB_ACK = 2;

    typedef enum logic {IN_EMPTY, IN_FULL} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_PEND} out_state_t;

endpackage

// File: rtl/ppi_edge_sync.sv
// Multi-flop synchroniser with rise/fall pulses; flops idle high so a
// released reset never manufactures an edge on a quiet strobe line.
module ppi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   q;

    assign q = sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus one delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            prev_q <= q;
        end
    end

    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/ppi_group_b_ctrl.sv
// Group B controller: control-word decode, Port B mode 0/1 and the
// PC0-PC2 strobed handshake, plus BSR access to Port C lower.
module ppi_group_b_ctrl
    import ppi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CL_W        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cw_wr,
    input  logic [7:0]        cw,
    input  logic              pb_wr,
    input  logic              pb_rd,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [DATA_W-1:0] pb_in,
    output logic [DATA_W-1:0] pb_out,
    output logic              pb_oe,
    input  logic [CL_W-1:0]   pcl_in,
    output logic [CL_W-1:0]   pcl_out,
    output logic [CL_W-1:0]   pcl_oe,
    output logic              mode_b,
    output logic              ovr
);

    logic              dir_b, dir_cl, inte_b, intr;
    logic [CL_W-1:0]   pcl_reg;
    logic [DATA_W-1:0] buf_q;
    in_state_t         in_st;
    out_state_t        out_st;

    logic              mode_b_nx, dir_b_nx, dir_cl_nx, inte_b_nx, intr_nx, ovr_nx;
    logic [CL_W-1:0]   pcl_reg_nx;
    logic [DATA_W-1:0] buf_nx, pb_out_nx, cpu_rdata_nx;
    in_state_t         in_st_nx;
    out_state_t        out_st_nx;

    logic stb_rise, stb_fall;
    logic mode1_in, mode1_out, ibf, obf_n;
    logic unused_pins;

    // Only PC2 is an input the handshake cares about
    assign unused_pins = ^{pcl_in, cw[6:4]};

    ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pcl_in[PC_STB_ACK]),
        .rise  (stb_rise),
        .fall  (stb_fall)
    );

    assign mode1_in  = mode_b & dir_b;
    assign mode1_out = mode_b & ~dir_b;
    assign ibf       = (in_st == IN_FULL);
    assign obf_n     = (out_st == OUT_IDLE);

    // State register for configuration, data paths and handshake FSMs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_b    <= 1'b0;
            dir_b     <= 1'b1;
            dir_cl    <= 1'b1;
            inte_b    <= 1'b0;
            intr      <= 1'b0;
            ovr       <= 1'b0;
            pcl_reg   <= '0;
            buf_q     <= '0;
            pb_out    <= '0;
            cpu_rdata <= '0;
            in_st     <= IN_EMPTY;
            out_st    <= OUT_IDLE;
        end else begin
            mode_b    <= mode_b_nx;
            dir_b     <= dir_b_nx;
            dir_cl    <= dir_cl_nx;
            inte_b    <= inte_b_nx;
            intr      <= intr_nx;
            ovr       <= ovr_nx;
            pcl_reg   <= pcl_reg_nx;
            buf_q     <= buf_nx;
            pb_out    <= pb_out_nx;
            cpu_rdata <= cpu_rdata_nx;
            in_st     <= in_st_nx;
            out_st    <= out_st_nx;
        end
    end

    // Next state; later clauses take priority (mode set last so it wins)
    always_comb begin
        mode_b_nx    = mode_b;
        dir_b_nx     = dir_b;
        dir_cl_nx    = dir_cl;
        inte_b_nx    = inte_b;
        intr_nx      = intr;
        ovr_nx       = ovr;
        pcl_reg_nx   = pcl_reg;
        buf_nx       = buf_q;
        pb_out_nx    = pb_out;
        cpu_rdata_nx = cpu_rdata;
        in_st_nx     = in_st;
        out_st_nx    = out_st;

        // Output handshake: ACK rise raises INTR, a CPU write beats ACK fall
        if (mode1_out && stb_rise)
            intr_nx = inte_b & obf_n;
        if (pb_wr) begin
            pb_out_nx = cpu_wdata;
            if (mode1_out) begin
                out_st_nx = OUT_PEND;
                intr_nx   = 1'b0;
            end
        end else if (mode1_out && stb_fall) begin
            out_st_nx = OUT_IDLE;
        end

        // CPU read, then input handshake
        if (pb_rd) begin
            cpu_rdata_nx = mode1_in ? buf_q : (dir_b ? pb_in : pb_out);
            ovr_nx       = 1'b0;
            if (mode1_in) begin
                intr_nx  = 1'b0;
                in_st_nx = IN_EMPTY;
            end
        end
        if (mode1_in && stb_rise && !pb_rd)
            intr_nx = inte_b & ibf;
        if (mode1_in && stb_fall) begin
            // A read on the same edge frees the buffer, so it is not an overrun
            if (!ibf || pb_rd) begin
                buf_nx   = pb_in;
                in_st_nx = IN_FULL;
            end else begin
                ovr_nx = 1'b1;
            end
        end

        // Bit set/reset; handshake pins are not CPU-writable in mode 1
        if (cw_wr && !cw[CW_MODESET]) begin
            for (int i = 0; i < CL_W; i++) begin
                if (int'(cw[BSR_SEL_HI:BSR_SEL_LO]) == i) begin
                    if (!mode_b) begin
                        pcl_reg_nx[i] = cw[BSR_VAL];
                    end else if (i == PC_STB_ACK) begin
                        inte_b_nx = cw[BSR_VAL];
                        if (!cw[BSR_VAL])
                            intr_nx = 1'b0;
                    end else if (i > PC_STB_ACK) begin
                        pcl_reg_nx[i] = cw[BSR_VAL];
                    end
                end
            end
        end

        // Mode set re-initialises the whole group
        if (cw_wr && cw[CW_MODESET]) begin
            mode_b_nx  = cw[CW_MODE_B];
            dir_b_nx   = cw[CW_DIR_B];
            dir_cl_nx  = cw[CW_DIR_CL];
            pb_out_nx  = '0;
            pcl_reg_nx = '0;
            inte_b_nx  = 1'b0;
            intr_nx    = 1'b0;
            ovr_nx     = 1'b0;
            in_st_nx   = IN_EMPTY;
            out_st_nx  = OUT_IDLE;
        end
    end

    assign pb_oe = ~dir_b;

    // Port C-lower pin muxing: handshake signals override PC0-PC2 in mode 1
    always_comb begin
        pcl_out = pcl_reg;
        pcl_oe  = {CL_W{~dir_cl}};
        if (mode_b) begin
            pcl_out[PC_INTR]    = intr;
            pcl_out[PC_BF]      = dir_b ? ibf : obf_n;
            pcl_out[PC_STB_ACK] = 1'b0;
            pcl_oe[PC_INTR]     = 1'b1;
            pcl_oe[PC_BF]       = 1'b1;
            pcl_oe[PC_STB_ACK]  = 1'b0;
        end
    end

endmodule

// File: doc/ppi_group_b_ctrl.md
# ppi_group_b_ctrl

Clocked Group B controller for the 8255-style PPI: decodes control words into Port B / Port C-lower configuration and runs Port B in mode 0 (simple I/O) or mode 1 (strobed I/O with handshake on PC0–PC2). Supports BSR writes to Port C lower, including the INTE_B enable. Sits between the CPU bus interface (read/write decode) and the Port B / Port C-lower pin drivers; parametrised successor of the combinational group B decoder.

## Interface
- DATA_W, 8, Port B width
- CL_W, 4, Port C-lower width; must be ≥ 4
- SYNC_STAGES, 2, synchroniser depth on pcl_in
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cw_wr  in  1  one-cycle control-word write strobe
- cw  in  8  control word
- pb_wr  in  1  one-cycle CPU write to Port B
- pb_rd  in  1  one-cycle CPU read of Port B
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered Port B read data
- pb_in  in  DATA_W  Port B pins, input
- pb_out  out  DATA_W  Port B output register
- pb_oe  out  1  Port B output enable
- pcl_in  in  CL_W  Port C-lower pins, input
- pcl_out  out  CL_W  Port C-lower output values
- pcl_oe  out  CL_W  Port C-lower per-bit output enable
- mode_b  out  1  0 = mode 0, 1 = mode 1
- ovr  out  1  sticky mode-1 input overrun, cleared by pb_rd

## Operation
- Reset: mode_b=0, Port B and C-lower inputs (pb_oe=0, pcl_oe=0), pb_out=0, pcl_out=0, cpu_rdata=0, INTE_B=0, IBF=0, OBF_n=1, INTR=0, ovr=0.
- cw_wr with cw[7]=1 (mode set): mode_b←cw[2]; Port B dir←cw[1] (1=input); C-lower dir←cw[0] (1=input). Clears pb_out, pcl_out, INTE_B, IBF, INTR, ovr; OBF_n←1.
- cw_wr with cw[7]=0 (BSR): bit index cw[3:1], value cw[0]. Index ≥ CL_W ignored (other group). Mode 0: sets pcl_out[index]. Mode 1: index 2 writes INTE_B; indices 0,1 ignored (handshake-owned); index 3 writes pcl_out[3].
- Mode 0: pb_oe = !dir; pb_wr loads pb_out (input mode: loads register, pins stay undriven); pb_rd returns pb_in (input) or pb_out (output). pcl_oe all = !C-lower dir.
- Mode 1: pcl_oe[0]=1 (INTR_B), pcl_oe[1]=1 (IBF_B input / OBF_B_n output), pcl_oe[2]=0 (STB_B_n / ACK_B_n), pcl_oe[3]=!C-lower dir.
- Mode 1 input FSM EMPTY→FULL: STB_n fall latches pb_in into buffer, IBF←1. STB_n rise: INTR←INTE_B&IBF. pb_rd returns buffer, clears INTR and IBF → EMPTY. STB_n fall while FULL: buffer kept, ovr←1.
- Mode 1 output FSM IDLE→PENDING: pb_wr loads pb_out, OBF_n←0, INTR←0. ACK_n fall: OBF_n←1 → IDLE. ACK_n rise: INTR←INTE_B&OBF_n. pb_wr in PENDING overwrites pb_out, OBF_n stays 0.
- INTE_B cleared by BSR: INTR←0 next cycle.

## Timing
- pcl_in passes SYNC_STAGES flops plus one edge-detect flop; state update on next edge: IBF/OBF_n change on rising edge 3 after pin transition (SYNC_STAGES=2). Minimum STB/ACK low and high width: 3 clk. pb_in must be stable over STB_n low.
- cpu_rdata valid the cycle after pb_rd; held until next pb_rd.
- cw_wr, pb_wr effects visible cycle after strobe.
- Simultaneous pb_rd and STB_n fall in FULL: read returns old buffer, new data latched, IBF stays 1, ovr not set.
- Simultaneous pb_wr and ACK_n fall: write wins, OBF_n stays 0.
- cw_wr mode set concurrent with pb_wr/pb_rd: mode set wins; pb_rd data still returned, state cleared.
- rst_n low mid-handshake: all outputs to reset values immediately; synchroniser flops reset to 1 (idle high), no spurious edge after release.

## Structure
- ppi_pkg: cw field positions (CW_MODESET=7, CW_MODE_B=2, CW_DIR_B=1, CW_DIR_CL=0, BSR_SEL 3:1), PCL indices (PC_INTR=0, PC_BF=1, PC_STB_ACK=2), FSM state typedefs.
- Sub-module ppi_edge_sync: SYNC_STAGES synchroniser plus rise/fall pulse outputs, instantiated for pcl_in[2].

## Test plan
- Reset, cw=0x82 (mode 0, B in, CL out) → pb_oe=0, pcl_oe=4'b1111; pb_in=0xA5, pb_rd → cpu_rdata=0xA5.
- Mode 0 BSR cw=0x07 then 0x06 → pcl_out[3]=1 then 0; cw=0x0F (index 7) → no change.
- cw=0x86, BSR 0x05 (INTE_B=1); STB_n pulse 4 clk with pb_in=0x3C → IBF=1 at edge 3, INTR=1 after rise; pb_rd → 0x3C, IBF=0, INTR=0.
- Mode 1 input, second STB_n before read with 0x99 → buffer 0x3C kept, ovr=1; pb_rd clears ovr.
- cw=0x84, INTE_B=1, pb_wr 0x5A → pb_out=0x5A, OBF_n=0; ACK_n pulse → OBF_n=1, INTR=1; pb_wr → INTR=0.
- rst_n low during STB_n low → IBF=0, pcl_oe=0, no IBF after release while STB_n returns high.
